// File: rtl/mem_stage_m_wb_if.sv
// Data-memory request/response bundle between the memory stage and the data memory.
// master: stage side (drives req/we/addr/wdata/wstrb); slave: memory side (drives ready/rvalid/rdata).
interface mem_stage_m_wb_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_m_wb.sv
// Memory stage plus M/WB register: issues loads/stores on dmem (master modport), formats load data,
// stalls upstream while a load response is pending. Ports: clk, rst (sync, active-high), *_M inputs
// from EX/M, stall_M, *_W writeback outputs. Optional macro MISALIGN_TRAP_EN traps misaligned LH/SH/LW/SW.
module mem_stage_m_wb #(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_M,
  input  logic [31:0] instr_M,
  input  logic [31:0] alu_result_M,
  input  logic [31:0] rs2_rdata_M,
  input  logic [2:0]  funct3_M,
  input  logic [4:0]  rd_waddr_M,
  input  logic        rd_wen_M,
  input  logic        MemWrite_M,
  input  logic        MemRead_M,
  input  logic [1:0]  PMAItoReg_M,
  output logic        stall_M,
  mem_stage_m_wb_if.master dmem,
  output logic [31:0] PC_W,
  output logic [31:0] instr_W,
  output logic [31:0] alu_result_W,
  output logic [31:0] load_data_W,
  output logic [4:0]  rd_waddr_W,
  output logic        rd_wen_W,
  output logic [1:0]  PMAItoReg_W,
  output logic        bus_err_W,
  output logic        misalign_W
);

  localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RESP_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_R} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic        mem_op, is_st, mis;
  logic        take, tout, rsp;
  logic [1:0]  ofs;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        sx;
  logic [31:0] fmt;

  assign mem_op = MemRead_M | MemWrite_M;
  assign is_st  = MemWrite_M;
  assign ofs    = alu_result_M[1:0];

`ifdef MISALIGN_TRAP_EN
  logic half_acc, word_acc;
  assign half_acc = (funct3_M == 3'b001)
                  | (~is_st & (funct3_M == 3'b101));
  assign word_acc = (funct3_M == 3'b010);
  assign mis = mem_op
             & ((half_acc & ofs[0]) | (word_acc & (ofs != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  // Request side
  assign dmem.we   = is_st;
  assign dmem.addr = {alu_result_M[31:2], 2'b00};

  always_comb begin
    dmem.wdata = rs2_rdata_M;
    dmem.wstrb = 4'b0000;
    unique case (funct3_M[1:0])
      2'b00: begin
        dmem.wdata = {4{rs2_rdata_M[7:0]}};
        dmem.wstrb = 4'b0001 << ofs;
      end
      2'b01: begin
        dmem.wdata = {2{rs2_rdata_M[15:0]}};
        dmem.wstrb = ofs[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem.wdata = rs2_rdata_M;
        dmem.wstrb = 4'b1111;
      end
    endcase
    if (!is_st) dmem.wstrb = 4'b0000;
  end

  // Load formatting
  always_comb begin
    lb = dmem.rdata[7:0];
    unique case (ofs)
      2'b00: lb = dmem.rdata[7:0];
      2'b01: lb = dmem.rdata[15:8];
      2'b10: lb = dmem.rdata[23:16];
      2'b11: lb = dmem.rdata[31:24];
    endcase
  end

  assign lh = ofs[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
  assign sx = ~funct3_M[2];

  always_comb begin
    fmt = dmem.rdata;
    unique case (1'b1)
      (funct3_M[1:0] == 2'b00): fmt = {{24{sx & lb[7]}}, lb};
      (funct3_M[1:0] == 2'b01): fmt = {{16{sx & lh[15]}}, lh};
      default:                  fmt = dmem.rdata;
    endcase
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dmem.req = 1'b0;
    stall_M  = 1'b0;
    take     = 1'b0;
    tout     = 1'b0;
    rsp      = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op && !mis) begin
          dmem.req = 1'b1;
          if (dmem.ready) begin
            if (is_st) begin
              take = 1'b1;
            end else begin
              state_n = WAIT_R;
              stall_M = 1'b1;
            end
          end else begin
            stall_M = 1'b1;
          end
        end else begin
          take = 1'b1;
        end
      end
      WAIT_R: begin
        // A response arriving on the last allowed cycle beats the timeout.
        if (dmem.rvalid) begin
          take    = 1'b1;
          rsp     = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          tout    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + 1'b1;
          stall_M = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // M/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_W         <= '0;
      instr_W      <= '0;
      alu_result_W <= '0;
      load_data_W  <= '0;
      rd_waddr_W   <= '0;
      rd_wen_W     <= 1'b0;
      PMAItoReg_W  <= '0;
      bus_err_W    <= 1'b0;
      misalign_W   <= 1'b0;
    end else if (stall_M) begin
      rd_wen_W   <= 1'b0;
      bus_err_W  <= 1'b0;
      misalign_W <= 1'b0;
    end else begin
      PC_W         <= PC_M;
      instr_W      <= instr_M;
      alu_result_W <= alu_result_M;
      rd_waddr_W   <= rd_waddr_M;
      PMAItoReg_W  <= PMAItoReg_M;
      load_data_W  <= rsp ? fmt : 32'h0;
      rd_wen_W     <= rd_wen_M & take & ~mis;
      bus_err_W    <= tout;
      misalign_W   <= mis;
    end
  end

endmodule

// File: tb/tb_mem_stage_m_wb.sv
// Self-checking bench for mem_stage_m_wb: directed cases plus random loads/stores
// checked against a behavioural model of lanes, load formatting and response timing.
module tb_mem_stage_m_wb;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] PC_M, instr_M, alu_result_M, rs2_rdata_M;
  logic [2:0]  funct3_M;
  logic [4:0]  rd_waddr_M;
  logic        rd_wen_M, MemWrite_M, MemRead_M;
  logic [1:0]  PMAItoReg_M;
  logic        stall_M;
  logic [31:0] PC_W, instr_W, alu_result_W, load_data_W;
  logic [4:0]  rd_waddr_W;
  logic        rd_wen_W, bus_err_W, misalign_W;
  logic [1:0]  PMAItoReg_W;

  mem_stage_m_wb_if dmem();

  mem_stage_m_wb #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .PC_M(PC_M), .instr_M(instr_M), .alu_result_M(alu_result_M),
    .rs2_rdata_M(rs2_rdata_M), .funct3_M(funct3_M),
    .rd_waddr_M(rd_waddr_M), .rd_wen_M(rd_wen_M),
    .MemWrite_M(MemWrite_M), .MemRead_M(MemRead_M),
    .PMAItoReg_M(PMAItoReg_M), .stall_M(stall_M),
    .dmem(dmem),
    .PC_W(PC_W), .instr_W(instr_W), .alu_result_W(alu_result_W),
    .load_data_W(load_data_W), .rd_waddr_W(rd_waddr_W),
    .rd_wen_W(rd_wen_W), .PMAItoReg_W(PMAItoReg_W),
    .bus_err_W(bus_err_W), .misalign_W(misalign_W)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;
  int          obs_stalls;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] v);
    if (f3[1:0] == 2'd0) return (v & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'd1) return (v & 32'hFFFF) * 32'h00010001;
    return v;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3,
                                         input logic [31:0] a);
    int o;
    o = int'(a % 4);
    if (f3[1:0] == 2'd0) return 4'(1 << o);
    if (f3[1:0] == 2'd1) return 4'(3 << ((o / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] v;
    if (f3[1:0] == 2'd0) begin
      v = (d >> (8 * (a % 4))) & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
      return v;
    end
    if (f3[1:0] == 2'd1) begin
      v = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
      return v;
    end
    return d;
  endfunction

  function automatic bit m_mis(input bit ld, input bit st,
                               input logic [2:0] f3,
                               input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    bit half, word;
    if (!(ld || st)) return 1'b0;
    half = (f3 == 3'd1) || (!st && f3 == 3'd5);
    word = (f3 == 3'd2);
    return (half && (a % 2 != 0)) || (word && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic nop();
    PC_M = '0; instr_M = '0; alu_result_M = '0; rs2_rdata_M = '0;
    funct3_M = '0; rd_waddr_M = '0; rd_wen_M = 1'b0;
    MemWrite_M = 1'b0; MemRead_M = 1'b0; PMAItoReg_M = '0;
    dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
  endtask

  task automatic chk_pass(input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] a, input logic [4:0] rd,
                          input logic [1:0] pma);
    chk("pc_w", PC_W, pc);
    chk("instr_w", instr_W, ins);
    chk("alu_w", alu_result_W, a);
    chk("rd_waddr_w", 32'(rd_waddr_W), 32'(rd));
    chk("pma_w", 32'(PMAItoReg_W), 32'(pma));
  endtask

  // Entered and left at posedge+1.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] rs2,
                        input logic [31:0] rd_data, input int rw,
                        input int vw, input bit rdw);
    logic [31:0] pc, ins;
    logic [4:0]  rd;
    logic [1:0]  pma;
    bit          mem, mis;
    pc = $urandom; ins = $urandom; rd = 5'($urandom);
    pma = 2'($urandom);
    mem = ld || st;
    mis = m_mis(ld, st, f3, a);
    obs_stalls = 0;
    PC_M = pc; instr_M = ins; alu_result_M = a; rs2_rdata_M = rs2;
    funct3_M = f3; rd_waddr_M = rd; rd_wen_M = rdw;
    MemRead_M = ld; MemWrite_M = st; PMAItoReg_M = pma;
    dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = rd_data;
    if (!mem || mis) begin
      @(negedge clk);
      chk("pass_stall", 32'(stall_M), 0);
      chk("pass_req", 32'(dmem.req), 0);
      @(posedge clk); #1;
      chk_pass(pc, ins, a, rd, pma);
      chk("pass_rdwen", 32'(rd_wen_W), 32'(rdw && !mis));
      chk("pass_buserr", 32'(bus_err_W), 0);
      chk("pass_mis", 32'(misalign_W), 32'(mis));
      chk("pass_ldata", load_data_W, 0);
      nop();
      return;
    end
    for (int i = 0; i < rw; i++) begin
      @(negedge clk);
      chk("nrdy_stall", 32'(stall_M), 1);
      chk("nrdy_req", 32'(dmem.req), 1);
      if (stall_M) obs_stalls++;
      @(posedge clk); #1;
      chk("nrdy_bubble", 32'(rd_wen_W), 0);
    end
    dmem.ready = 1'b1;
    @(negedge clk);
    obs_addr = dmem.addr; obs_wdata = dmem.wdata; obs_wstrb = dmem.wstrb;
    if (stall_M) obs_stalls++;
    chk("req", 32'(dmem.req), 1);
    chk("we", 32'(dmem.we), 32'(st));
    chk("addr", dmem.addr, a & 32'hFFFF_FFFC);
    chk("wstrb", 32'(dmem.wstrb), st ? 32'(m_wstrb(f3, a)) : 0);
    if (st) chk("wdata", dmem.wdata, m_wdata(f3, rs2));
    chk("acc_stall", 32'(stall_M), st ? 0 : 1);
    @(posedge clk); #1;
    dmem.ready = 1'b0;
    if (st) begin
      chk_pass(pc, ins, a, rd, pma);
      chk("st_rdwen", 32'(rd_wen_W), 32'(rdw));
      chk("st_buserr", 32'(bus_err_W), 0);
      nop();
      return;
    end
    for (int k = 0; k < TO; k++) begin
      dmem.rvalid = (k == vw);
      @(negedge clk);
      chk("wr_req", 32'(dmem.req), 0);
      if (k == vw) begin
        chk("rsp_stall", 32'(stall_M), 0);
        @(posedge clk); #1;
        chk_pass(pc, ins, a, rd, pma);
        chk("ld_data", load_data_W, m_load(f3, a, rd_data));
        chk("ld_rdwen", 32'(rd_wen_W), 32'(rdw));
        chk("ld_buserr", 32'(bus_err_W), 0);
        break;
      end else if (k == TO - 1) begin
        chk("to_stall", 32'(stall_M), 0);
        @(posedge clk); #1;
        chk("to_ldata", load_data_W, 0);
        chk("to_buserr", 32'(bus_err_W), 1);
        chk("to_rdwen", 32'(rd_wen_W), 0);
        break;
      end else begin
        chk("wr_stall", 32'(stall_M), 1);
        if (stall_M) obs_stalls++;
        @(posedge clk); #1;
        chk("wr_bubble", 32'(rd_wen_W), 0);
      end
    end
    nop();
  endtask

  logic [2:0] ld_f3 [5];
  logic [2:0] st_f3 [3];

  initial begin
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3 = '{3'd0, 3'd1, 3'd2};
    nop();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", PC_W, 0);
    chk("rst_ldata", load_data_W, 0);
    chk("rst_rdwen", 32'(rd_wen_W), 0);
    chk("rst_buserr", 32'(bus_err_W), 0);
    chk("rst_mis", 32'(misalign_W), 0);
    rst = 1'b0;

    // SW 0x104
    run_op(0, 1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("sw_wstrb", 32'(obs_wstrb), 32'hF);
    chk("sw_addr", obs_addr, 32'h104);
    chk("sw_rdwen", 32'(rd_wen_W), 0);

    // LB 0x203, response 3 cycles after acceptance
    run_op(1, 0, 3'd0, 32'h203, 0, 32'h80123456, 0, 2, 1);
    chk("lb_stalls", 32'(obs_stalls), 3);
    chk("lb_data", load_data_W, 32'hFFFFFF80);

    // LHU 0x202
    run_op(1, 0, 3'd5, 32'h202, 0, 32'hBEEF1234, 1, 0, 1);
    chk("lhu_data", load_data_W, 32'h0000BEEF);

    // SB 0x1
    run_op(0, 1, 3'd0, 32'h1, 32'hAB, 0, 0, 0, 0);
    chk("sb_wdata", obs_wdata, 32'hABABABAB);
    chk("sb_wstrb", 32'(obs_wstrb), 32'h2);

    // Load timeout
    run_op(1, 0, 3'd2, 32'h300, 0, 32'h12345678, 0, TO + 5, 1);
    run_op(0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 1);
    chk("after_to_buserr", 32'(bus_err_W), 0);

    // Response on the last allowed cycle still wins
    run_op(1, 0, 3'd2, 32'h400, 0, 32'hCAFEF00D, 0, TO - 1, 1);
    chk("late_rsp", load_data_W, 32'hCAFEF00D);

    // Reset while waiting, stray response afterwards
    PC_M = 32'h500; instr_M = 32'h3; alu_result_M = 32'h500;
    funct3_M = 3'd2; rd_waddr_M = 5'd7; rd_wen_M = 1'b1;
    MemRead_M = 1'b1; dmem.ready = 1'b1;
    @(posedge clk); #1;
    dmem.ready = 1'b0;
    @(negedge clk);
    chk("rst_wait_stall", 32'(stall_M), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nop();
    dmem.rvalid = 1'b1; dmem.rdata = 32'h99999999;
    chk("rstw_pc", PC_W, 0);
    chk("rstw_alu", alu_result_W, 0);
    @(negedge clk);
    chk("stray_stall", 32'(stall_M), 0);
    chk("stray_req", 32'(dmem.req), 0);
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    chk("stray_ldata", load_data_W, 0);
    chk("stray_rdwen", 32'(rd_wen_W), 0);
    chk("stray_rd", 32'(rd_waddr_W), 0);
    run_op(1, 0, 3'd1, 32'h602, 0, 32'h8001FFFF, 0, 1, 1);
    chk("post_rst_lh", load_data_W, 32'hFFFF8001);

    // Misaligned LW 0x102
    run_op(1, 0, 3'd2, 32'h102, 0, 32'h11223344, 0, 0, 1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag", 32'(misalign_W), 1);
    chk("mis_rdwen", 32'(rd_wen_W), 0);
`else
    chk("mis_addr", obs_addr, 32'h100);
    chk("mis_data", load_data_W, 32'h11223344);
`endif

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      int kind, rw, vw;
      logic [2:0] f3;
      kind = $urandom_range(0, 3);
      rw = $urandom_range(0, 2);
      vw = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
      case (kind)
        1: begin
          f3 = ld_f3[$urandom_range(0, 4)];
          run_op(1, 0, f3, $urandom, $urandom, $urandom, rw, vw, 1'($urandom));
        end
        2, 3: begin
          f3 = st_f3[$urandom_range(0, 2)];
          run_op(kind == 3, 1, f3, $urandom, $urandom, 0, rw, 0, 0);
        end
        default: begin
          run_op(0, 0, 3'($urandom), $urandom, $urandom, 0, 0, 0, 1'($urandom));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
